uart_bootloader_top: RTL and testbench

//  FPGA top level for the UART bootloader board bring-up stage.
//  - Receives 8N1 UART bytes from the FTDI bridge on ftdi_rx.
//  - Shows the low nibble of the last good byte on LEDs D1..D4.
//  - Toggles led_green once per good byte.
//  - Optionally echoes each byte back on ftdi_tx.

---
 rtl/uart_bootloader_top.sv | 189 ++++++++++++++++++
 tb/tb_uart_bootloader_top.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_bootloader_top.sv
// UART bootloader bring-up top: 8N1 receiver driving LEDs, with an optional echo transmitter.
// Define UART_ECHO_EN to build the TX echo path; otherwise ftdi_tx is tied high.
module uart_bootloader_top #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic hwclk,
    input  logic resetn,
    input  logic ftdi_rx,
    output logic ftdi_tx,
    output logic led_green,
    output logic D1,
    output logic D2,
    output logic D3,
    output logic D4
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE} rx_state_t;

    logic            rx_meta, rx_sync;
    rx_state_t       rx_state, rx_state_nxt;
    logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
    logic [2:0]      rx_bit, rx_bit_nxt;
    logic [7:0]      rx_shift, rx_shift_nxt;
    logic            rx_dv, rx_dv_nxt;
    logic [3:0]      leds;

    // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge hwclk or posedge resetn) begin
        if (resetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= ftdi_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge hwclk or posedge resetn) begin
        if (resetn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_dv    <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rx_dv    <= rx_dv_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_dv_nxt    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                rx_bit_nxt = '0;
                if (!rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    // LSB first: after 8 right-shifts bit 0 of the byte sits at rx_shift[0].
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                    else                rx_bit_nxt   = rx_bit + 1'b1;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_dv_nxt    = rx_sync;
                    rx_state_nxt = RX_DONE;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DONE: rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge hwclk or posedge resetn) begin
        if (resetn) begin
            leds      <= '0;
            led_green <= 1'b0;
        end else if (rx_dv) begin
            leds      <= rx_shift[3:0];
            led_green <= ~led_green;
        end
    end

    assign {D4, D3, D2, D1} = leds;

`ifdef UART_ECHO_EN
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_data, tx_data_nxt;
    logic          tx_line, tx_line_nxt;

    always_ff @(posedge hwclk or posedge resetn) begin
        if (resetn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_data  <= tx_data_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    // A byte arriving while busy is ignored, so the frame on the wire is never disturbed.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_data_nxt  = tx_data;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                tx_bit_nxt = '0;
                if (rx_dv) begin
                    tx_data_nxt  = rx_shift;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
                    else                tx_bit_nxt   = tx_bit + 1'b1;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) tx_state_nxt = TX_IDLE;
                else                    tx_cnt_nxt   = tx_cnt + 1'b1;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START: tx_line_nxt = 1'b0;
            TX_DATA:  tx_line_nxt = tx_data_nxt[tx_bit_nxt];
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    assign ftdi_tx = tx_line;
`else
    assign ftdi_tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_bootloader_top.sv
// Directed + randomized bench for uart_bootloader_top against a byte-level LED/echo model.
module tb_uart_bootloader_top;
    logic hwclk = 1'b0;
    logic resetn = 1'b1;
    logic ftdi_rx = 1'b1;
    logic ftdi_tx, led_green, D1, D2, D3, D4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_led = 4'h0;
    logic       exp_green = 1'b0;

    uart_bootloader_top #(.CLKS_PER_BIT(104)) dut (
        .hwclk(hwclk), .resetn(resetn), .ftdi_rx(ftdi_rx), .ftdi_tx(ftdi_tx),
        .led_green(led_green), .D1(D1), .D2(D2), .D3(D3), .D4(D4)
    );

    always #1 hwclk = ~hwclk;

`ifndef UART_ECHO_EN
    int tx_glitch = 0;
    always @(negedge hwclk) if (ftdi_tx !== 1'b1) tx_glitch++;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_led"}, {28'd0, D4, D3, D2, D1}, {28'd0, exp_led});
        chk({tag, "_grn"}, {31'd0, led_green}, {31'd0, exp_green});
    endtask

    // One 8N1 frame, 208 time units per bit; stop_ok=0 sends a framing error.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        ftdi_rx = 1'b0;
        #208;
        for (int i = 0; i < 8; i++) begin
            ftdi_rx = b[i];
            #208;
        end
        ftdi_rx = stop_ok;
        #208;
        ftdi_rx = 1'b1;
    endtask

    // Model: only a frame with a good stop bit changes the display.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_led   = b[3:0];
            exp_green = ~exp_green;
        end
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] b, input logic stop_ok);
        send_byte(b, stop_ok);
        model_frame(b, stop_ok);
        chk_state(tag);
    endtask

`ifdef UART_ECHO_EN
    task automatic cap_tx(output logic [9:0] frame, output logic found);
        int w = 0;
        frame = '0;
        while (ftdi_tx !== 1'b0 && w < 3000) begin
            @(negedge hwclk);
            w++;
        end
        found = (w < 3000);
        if (found) begin
            repeat (52) @(negedge hwclk);
            for (int i = 0; i < 10; i++) begin
                frame[i] = ftdi_tx;
                if (i < 9) repeat (104) @(negedge hwclk);
            end
        end
    endtask
`endif

    initial begin
        logic [7:0] rb;
        logic       rs, prev_ok;
        int         gap;

        // Reset
        #10;
        chk("rst_hold_tx", {31'd0, ftdi_tx}, 32'd1);
        chk_state("rst_hold");
        #10;
        resetn = 1'b0;
        #200;
        chk("rst_rel_tx", {31'd0, ftdi_tx}, 32'd1);
        chk_state("rst_rel");

        // Sequential low-nibble bytes
        for (int i = 0; i < 8; i++) begin
            frame_and_check($sformatf("seq%0d", i), 8'(i), 1'b1);
            #5000;
        end
        chk("seq_green_end", {31'd0, led_green}, 32'd0);

        // 0x5A, with echo when built in
`ifdef UART_ECHO_EN
        begin
            logic [9:0] fr;
            logic       found;
            fork
                send_byte(8'h5A, 1'b1);
                cap_tx(fr, found);
            join
            chk("echo_found", {31'd0, found}, 32'd1);
            chk("echo_frame", {22'd0, fr}, {22'd0, 1'b1, 8'h5A, 1'b0});
        end
        model_frame(8'h5A, 1'b1);
        chk_state("b5a");
`else
        frame_and_check("b5a", 8'h5A, 1'b1);
`endif
        #5000;

        // Framing error then a good byte
        frame_and_check("ferr", 8'h03, 1'b0);
        #5000;
        frame_and_check("after_ferr", 8'h05, 1'b1);
        #5000;

        // Short low glitch
        ftdi_rx = 1'b0;
        #40;
        ftdi_rx = 1'b1;
        #2000;
        chk_state("glitch");
        frame_and_check("after_glitch", 8'h0F, 1'b1);
        #5000;

        // Reset in the middle of data bit 4
        rb = 8'hC9;
        ftdi_rx = 1'b0;
        #208;
        for (int i = 0; i < 4; i++) begin
            ftdi_rx = rb[i];
            #208;
        end
        ftdi_rx = rb[4];
        #100;
        resetn  = 1'b1;
        ftdi_rx = 1'b1;
        exp_led   = 4'h0;
        exp_green = 1'b0;
        #10;
        chk("midrst_tx", {31'd0, ftdi_tx}, 32'd1);
        chk_state("midrst");
        #10;
        resetn = 1'b0;
        #5000;
        chk_state("midrst_idle");
        frame_and_check("after_rst", 8'h06, 1'b1);
        #5000;

        // Randomized frames, including back-to-back ones after a good stop bit
        prev_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            gap = prev_ok ? $urandom_range(0, 2) * 1000 : 2000;
            #(gap);
            frame_and_check($sformatf("rnd%0d", i), rb, rs);
            prev_ok = rs;
        end
        #5000;

`ifndef UART_ECHO_EN
        chk("tx_tied_high", tx_glitch, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
